dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 137 +++++++++++++
 tb/tb_dmem_responder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data memory responder; DMEM_B2B_EN enables back-to-back accept
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            accept;
    logic            enter_resp;

    logic            lat_we;
    logic [31:0]     lat_addr;
    logic [31:0]     lat_wdata;
    logic [3:0]      lat_be;

    logic            op_we;
    logic [31:0]     op_addr;
    logic [31:0]     op_wdata;
    logic [3:0]      op_be;
    logic            op_err;
    logic [AW-1:0]   op_idx;

    logic [31:0]     mem [DEPTH_WORDS];

    // Entering RESP from WAIT uses the latched request; any other entry is the live accept.
    always_comb begin
        op_we    = (state_q == WAIT) ? lat_we    : req_we;
        op_addr  = (state_q == WAIT) ? lat_addr  : req_addr;
        op_wdata = (state_q == WAIT) ? lat_wdata : req_wdata;
        op_be    = (state_q == WAIT) ? lat_be    : req_be;
        op_err   = (op_addr[1:0] != 2'b00) || (op_addr[31:AW+2] != '0);
        op_idx   = op_addr[AW+1:2];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid;
            end
            WAIT: begin
                if (cnt_q == CW'(1)) begin
                    state_d    = RESP;
                    cnt_d      = '0;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
`ifdef DMEM_B2B_EN
                    req_ready = 1'b1;
                    accept    = req_valid;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            if (LATENCY == 1) begin
                state_d    = RESP;
                enter_resp = 1'b1;
            end else begin
                state_d = WAIT;
                cnt_d   = CW'(LATENCY - 1);
            end
        end
    end

    assign rsp_valid = (state_q == RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
            end
            if (enter_resp) begin
                rsp_err   <= op_err;
                rsp_rdata <= (op_err || op_we) ? 32'h0 : mem[op_idx];
            end
        end
    end

    // Contents survive reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && op_we && !op_err) begin
            for (int b = 0; b < 4; b++) begin
                if (op_be[b]) mem[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder
module tb_dmem_responder;

    localparam int LAT = 2;
    localparam int DW  = 1024;
`ifdef DMEM_B2B_EN
    localparam int PERIOD = LAT;
`else
    localparam int PERIOD = LAT + 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int passed = 0;
    logic [32:0] exp_q[$];
    logic [31:0] model[int];

    dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [32:0] predict(input logic we, input logic [31:0] addr,
                                            input logic [31:0] wdata, input logic [3:0] be);
        logic [31:0] w;
        int idx;
        idx = int'(addr[31:2]);
        if (addr[1:0] != 2'b00 || addr[31:2] >= DW) return {1'b1, 32'h0};
        if (we) begin
            w = model.exists(idx) ? model[idx] : 32'h0;
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
            model[idx] = w;
            return 33'h0;
        end
        return {1'b0, model.exists(idx) ? model[idx] : 32'h0};
    endfunction

    task automatic pop_check(input string tag);
        logic [32:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "/unexpected_rsp"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "/rdata"}, rsp_rdata, e[31:0]);
        check({tag, "/err"}, {31'h0, rsp_err}, {31'h0, e[32]});
    endtask

    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int hold);
        int n;
        logic [31:0] held;
        logic stable;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        n = 0;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        check({tag, "/ready"}, {31'h0, req_ready}, 32'd1);
        exp_q.push_back(predict(we, addr, wdata, be));
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        check({tag, "/latency"}, n, LAT);
        held = rsp_rdata;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (!rsp_valid || rsp_rdata !== held || req_ready !== 1'b0) stable = 1'b0;
            @(posedge clk); #1;
        end
        if (hold > 0) check({tag, "/hold_stable"}, {31'h0, stable}, 32'd1);
        rsp_ready = 1'b1;
        pop_check(tag);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, "/idle_after"}, {31'h0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc[$];
        int n;
        logic quiet;

        repeat (3) @(posedge clk);
        #1;
        check("reset/rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check("reset/rsp_err", {31'h0, rsp_err}, 32'd0);
        check("reset/rsp_rdata", rsp_rdata, 32'd0);
        rst = 1'b0;
        check("reset/req_ready", {31'h0, req_ready}, 32'd1);

        xact("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        xact("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 0);
        xact("st20", 1'b1, 32'h20, 32'h11223344, 4'hF, 0);
        xact("st20_be5", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0);
        xact("ld20", 1'b0, 32'h20, 32'h0, 4'h0, 0);
        xact("st20_be0", 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0);
        xact("ld20_again", 1'b0, 32'h20, 32'h0, 4'hF, 0);
        xact("ld22_misal", 1'b0, 32'h22, 32'h0, 4'h0, 0);
        xact("ld1000_oor", 1'b0, 32'h1000, 32'h0, 4'h0, 0);
        xact("st0", 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 0);
        xact("st1000_oor", 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0);
        xact("ld0", 1'b0, 32'h0, 32'h0, 4'h0, 0);
        xact("ld10_hold", 1'b0, 32'h10, 32'h0, 4'h0, 5);

        xact("st30", 1'b1, 32'h30, 32'h55AA55AA, 4'hF, 0);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h12345678; req_be = 4'hF;
        n = 0;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_wait/in_wait", {31'h0, rsp_valid}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_wait/req_ready", {31'h0, req_ready}, 32'd1);
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) quiet = 1'b0;
            @(posedge clk); #1;
        end
        check("rst_wait/no_rsp", {31'h0, quiet}, 32'd1);
        xact("ld30", 1'b0, 32'h30, 32'h0, 4'h0, 0);

        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (rsp_valid) pop_check("stream");
            if (req_ready) begin
                acc.push_back(cyc);
                exp_q.push_back(predict(1'b0, 32'h10, 32'h0, 4'h0));
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            if (rsp_valid) pop_check("drain");
            @(posedge clk); #1;
            n++;
        end
        rsp_ready = 1'b0;
        check("stream/drained", exp_q.size(), 32'd0);
        check("stream/accepts", {31'h0, acc.size() >= 5}, 32'd1);
        for (int i = 1; i < acc.size(); i++) check("stream/period", acc[i] - acc[i-1], PERIOD);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
